// File: rtl/aes_pkg.sv
// Shared AES constants: forward/inverse S-box tables, mode encoding and the
// state encoding of the folded SubBytes controller.
package aes_pkg;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/sbox_lane.sv
// One combinational S-box lane; mode picks the forward or inverse table.
module sbox_lane
    import aes_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic       mode_i,
    output logic [7:0] data_o
);

    // table lookup, forward for encryption, inverse for decryption
    always_comb begin
        data_o = SBOX[data_i];
        case (mode_i)
            MODE_ENC: data_o = SBOX[data_i];
            default:  data_o = INV_SBOX[data_i];
        endcase
    end

endmodule

// File: rtl/sub_bytes_folded.sv
// Folded AES SubBytes: LANES S-boxes substitute the state over NBEATS beats.
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// BUSY  | beat counter walks 0..NBEATS-1, LANES bytes per beat
// DONE  | OUT complete, out_valid high until downstream takes it
module sub_bytes_folded
    import aes_pkg::*;
#(
    parameter int BLOCK_LENGTH = 128,
    parameter int LANES        = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BLOCK_LENGTH-1:0] IN,
    input  logic                    mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BLOCK_LENGTH-1:0] OUT,
    output logic                    busy
);

    localparam int NBEATS = BLOCK_LENGTH / (8 * LANES);
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int BW     = 8 * LANES;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

    // Beat-major views: element 0 holds the most significant bytes, i.e. byte 0
    // upward, so indexing by the counter is a plain part-select.
    state_e                         state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [0:NBEATS-1][BW-1:0]      in_q, in_d;
    logic [0:NBEATS-1][BW-1:0]      out_q, out_d;
    logic                           mode_q, mode_d;
    logic [0:LANES-1][7:0]          lane_in, lane_out;
    logic                           accept;

    assign in_ready  = rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign OUT       = out_q;
    assign accept    = in_valid && in_ready;
    assign lane_in   = in_q[cnt_q];

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        sbox_lane u_lane (
            .data_i (lane_in[j]),
            .mode_i (mode_q),
            .data_o (lane_out[j])
        );
    end

    // next-state, beat sequencing and output-register update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        in_d    = in_q;
        mode_d  = mode_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    in_d    = IN;
                    mode_d  = mode;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                out_d[cnt_q] = lane_out;
                if (cnt_q == LAST_BEAT) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (accept) begin
                    in_d    = IN;
                    mode_d  = mode;
                    cnt_d   = '0;
                    state_d = BUSY;
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset discards any block in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            in_q    <= '0;
            mode_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            in_q    <= in_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_sub_bytes_folded.sv
// Directed bench for sub_bytes_folded: FIPS-197 vectors, constant-byte blocks,
// backpressure, streaming, mid-block reset and a lane-count sweep.
module tb_sub_bytes_folded;

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] ALL00    = 128'h00000000000000000000000000000000;
    localparam logic [127:0] ALL63    = 128'h63636363636363636363636363636363;
    localparam logic [127:0] ALLFF    = 128'hffffffffffffffffffffffffffffffff;
    localparam logic [127:0] ALL16    = 128'h16161616161616161616161616161616;
    localparam logic [127:0] ALL53    = 128'h53535353535353535353535353535353;
    localparam logic [127:0] ALLED    = 128'hedededededededededededededededed;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, mode, out_valid, out_ready, busy;
    logic [127:0] din, dout;

    logic         sw_valid, sw_mode, sw_out_ready;
    logic [127:0] sw_din;
    logic         sw_in_ready  [4];
    logic         sw_out_valid [4];
    logic         sw_busy      [4];
    logic [127:0] sw_out       [4];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sub_bytes_folded #(.BLOCK_LENGTH(128), .LANES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .IN        (din),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .OUT       (dout),
        .busy      (busy)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        sub_bytes_folded #(
            .BLOCK_LENGTH (128),
            .LANES        (g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 8 : 16)
        ) u_sw (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (sw_valid),
            .in_ready  (sw_in_ready[g]),
            .IN        (sw_din),
            .mode      (sw_mode),
            .out_valid (sw_out_valid[g]),
            .out_ready (sw_out_ready),
            .OUT       (sw_out[g]),
            .busy      (sw_busy[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one block from IDLE with out_ready low; leaves the DUT in DONE.
    task automatic run_block(input string tag, input logic [127:0] d, input logic m,
                             input logic [127:0] exp);
        int lat, nb;
        check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        din = d; mode = m; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0; nb = 0;
        while (!out_valid && lat < 100) begin
            if (busy) nb++;
            tick();
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'(4));
        check({tag, "_busy_cycles"}, 128'(nb), 128'(4));
        check({tag, "_out_valid"}, 128'(out_valid), 128'(1));
        check({tag, "_out"}, dout, exp);
    endtask

    task automatic release_done();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nb, t, tprev;
        int sw_lat [4];
        logic [127:0] sv [4];
        logic [127:0] se [4];
        int exp_lat [4];

        rst = 1'b0; in_valid = 1'b0; din = '0; mode = 1'b0; out_ready = 1'b0;
        sw_valid = 1'b0; sw_din = '0; sw_mode = 1'b0; sw_out_ready = 1'b0;
        #12;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out", dout, 128'(0));
        rst = 1'b1;
        tick();
        check("post_rst_in_ready", 128'(in_ready), 128'(1));

        // forward FIPS vector, then hold it under backpressure
        run_block("fips_enc", FIPS_IN, 1'b0, FIPS_OUT);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_out", dout, FIPS_OUT);
            check("bp_out_valid", 128'(out_valid), 128'(1));
            check("bp_in_ready", 128'(in_ready), 128'(0));
        end

        // release with a new block waiting: accepted in the DONE cycle
        out_ready = 1'b1; din = FIPS_OUT; mode = 1'b1; in_valid = 1'b1;
        #1;
        check("b2b_in_ready", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_busy", 128'(busy), 128'(1));
        check("b2b_out_valid_low", 128'(out_valid), 128'(0));
        lat = 0; nb = 0;
        while (!out_valid && lat < 100) begin
            if (busy) nb++;
            tick();
            lat++;
        end
        check("b2b_latency", 128'(lat), 128'(4));
        check("b2b_busy_cycles", 128'(nb), 128'(4));
        check("fips_dec_out", dout, FIPS_IN);
        release_done();

        run_block("zero_enc", ALL00, 1'b0, ALL63);
        release_done();
        run_block("ones_enc", ALLFF, 1'b0, ALL16);
        release_done();
        run_block("s63_dec", ALL63, 1'b1, ALL00);
        release_done();

        // continuous streaming with out_ready held high
        sv[0] = ALL00; sv[1] = FIPS_IN;  sv[2] = ALLFF; sv[3] = ALL53;
        se[0] = ALL63; se[1] = FIPS_OUT; se[2] = ALL16; se[3] = ALLED;
        out_ready = 1'b1; mode = 1'b0; din = sv[0]; in_valid = 1'b1;
        tick();
        t = 0; tprev = 0;
        for (int k = 0; k < 4; k++) begin
            lat = 0;
            while (!out_valid && lat < 50) begin
                tick();
                lat++;
                t++;
            end
            check("stream_out", dout, se[k]);
            check("stream_latency", 128'(lat), 128'(4));
            if (k > 0) check("stream_period", 128'(t - tprev), 128'(5));
            tprev = t;
            if (k < 3) din = sv[k + 1];
            else in_valid = 1'b0;
            tick();
            t++;
        end
        out_ready = 1'b0;
        check("stream_idle_in_ready", 128'(in_ready), 128'(1));

        // reset during beat 2 discards the block in flight
        din = FIPS_IN; mode = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("midrst_busy_before", 128'(busy), 128'(1));
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_in_ready", 128'(in_ready), 128'(0));
        check("midrst_out", dout, 128'(0));
        #2;
        rst = 1'b1;
        tick();
        check("midrst_out_valid_after", 128'(out_valid), 128'(0));
        run_block("post_midrst", ALL53, 1'b0, ALLED);
        release_done();

        // lane-count sweep on the FIPS vector
        exp_lat[0] = 16; exp_lat[1] = 8; exp_lat[2] = 2; exp_lat[3] = 1;
        for (int g = 0; g < 4; g++) begin
            sw_lat[g] = -1;
            check("sweep_in_ready", 128'(sw_in_ready[g]), 128'(1));
        end
        sw_din = FIPS_IN; sw_mode = 1'b0; sw_valid = 1'b1;
        tick();
        sw_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            for (int g = 0; g < 4; g++)
                if (sw_lat[g] < 0 && sw_out_valid[g]) sw_lat[g] = c;
            tick();
        end
        for (int g = 0; g < 4; g++) begin
            check("sweep_latency", 128'(sw_lat[g]), 128'(exp_lat[g]));
            check("sweep_out", sw_out[g], FIPS_OUT);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
